// File: rtl/ten_bit_pc_sequencer_pkg.sv
// Shared definitions for the 10-bit fetch address sequencer.
package ten_bit_pc_sequencer_pkg;

  localparam int unsigned ADDR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/ten_bit_incrementer.sv
// Combinational 10-bit +1 with carry-out.
module ten_bit_incrementer
  import ten_bit_pc_sequencer_pkg::*;
(
  input  logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] s,
  output logic              o
);

  assign {o, s} = {1'b0, a} + (ADDR_W + 1)'(1);

endmodule

// File: rtl/ten_bit_pc_sequencer.sv
// Registered fetch address sequencer: valid/ready issue, +1 per accepted
// transfer, absolute loads, sticky wrap flag and optional halt on wrap.
module ten_bit_pc_sequencer
  import ten_bit_pc_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC     = 10'd0,
  parameter bit                HALT_ON_WRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  input  logic              pc_ready,
  output logic              wrap,
  output logic              halted
);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              wrap_nxt;
  logic              pc_valid_nxt;
  logic              halted_nxt;
  logic [ADDR_W-1:0] inc_s;
  logic              inc_o;

  ten_bit_incrementer u_inc (
    .a (pc),
    .s (inc_s),
    .o (inc_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      wrap     <= 1'b0;
      pc_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      wrap     <= wrap_nxt;
      pc_valid <= pc_valid_nxt;
      halted   <= halted_nxt;
    end
  end

  // Load beats the handshake; the old pc still counts as transferred.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    wrap_nxt  = wrap;
    unique case (state)
      ST_IDLE: begin
        state_nxt = ST_RUN;
        if (load) begin
          pc_nxt   = load_addr;
          wrap_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        if (load) begin
          pc_nxt   = load_addr;
          wrap_nxt = 1'b0;
        end else if (pc_ready) begin
          pc_nxt = inc_s;
          if (inc_o) begin
            wrap_nxt = 1'b1;
            if (HALT_ON_WRAP) state_nxt = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (load) begin
          pc_nxt    = load_addr;
          wrap_nxt  = 1'b0;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    pc_valid_nxt = (state_nxt == ST_RUN);
    halted_nxt   = (state_nxt == ST_HALT);
  end

endmodule

// File: tb/tb_ten_bit_pc_sequencer.sv
// Self-checking bench: halting and free-running sequencers against a queue-free reference model.
module tb_ten_bit_pc_sequencer;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [9:0] load_addr = 10'd0;
  logic       pc_ready = 1'b0;

  logic [9:0] pc_h, pc_n;
  logic       pc_valid_h, pc_valid_n, wrap_h, wrap_n, halted_h, halted_n;
  logic [9:0] inc_a = 10'd0;
  logic [9:0] inc_s;
  logic       inc_o;

  int vectors = 0;
  int miscompares = 0;

  int m_mode[2];
  int m_pc[2];
  int m_wrap[2];
  int m_hw[2];

  always #5 clk = ~clk;

  ten_bit_pc_sequencer #(.RESET_PC(10'd0), .HALT_ON_WRAP(1'b1)) dut_halt (
    .clk(clk), .rst_n(rst_n), .load(load), .load_addr(load_addr),
    .pc(pc_h), .pc_valid(pc_valid_h), .pc_ready(pc_ready),
    .wrap(wrap_h), .halted(halted_h)
  );

  ten_bit_pc_sequencer #(.RESET_PC(10'd0), .HALT_ON_WRAP(1'b0)) dut_run (
    .clk(clk), .rst_n(rst_n), .load(load), .load_addr(load_addr),
    .pc(pc_n), .pc_valid(pc_valid_n), .pc_ready(pc_ready),
    .wrap(wrap_n), .halted(halted_n)
  );

  ten_bit_incrementer dut_inc (.a(inc_a), .s(inc_s), .o(inc_o));

  function automatic logic [12:0] obs_of(int i);
    if (i == 0) return {pc_h, pc_valid_h, wrap_h, halted_h};
    return {pc_n, pc_valid_n, wrap_n, halted_n};
  endfunction

  function automatic logic [12:0] exp_of(int i);
    return {10'(m_pc[i]), m_mode[i] == M_RUN, m_wrap[i] != 0, m_mode[i] == M_HALT};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE;
      m_pc[i]   = 0;
      m_wrap[i] = 0;
    end
  endtask

  // Behavioural rules evaluated with the inputs seen at the clock edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (m_mode[i] == M_IDLE) begin
        if (load) begin m_pc[i] = int'(load_addr); m_wrap[i] = 0; end
        m_mode[i] = M_RUN;
      end else if (m_mode[i] == M_RUN) begin
        if (load) begin
          m_pc[i] = int'(load_addr); m_wrap[i] = 0;
        end else if (pc_ready) begin
          if (m_pc[i] == 1023) begin
            m_wrap[i] = 1;
            if (m_hw[i] != 0) m_mode[i] = M_HALT;
          end
          m_pc[i] = (m_pc[i] + 1) % 1024;
        end
      end else if (load) begin
        m_pc[i] = int'(load_addr); m_wrap[i] = 0; m_mode[i] = M_RUN;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic ld, input int addr, input logic rdy);
    load = ld;
    load_addr = 10'(addr);
    pc_ready = rdy;
  endtask

  task automatic test_incrementer();
    int vals[5] = '{0, 1, 36, 1022, 1023};
    logic [10:0] exp_v;
    for (int k = 0; k < 5; k++) begin
      inc_a = 10'(vals[k]);
      #1;
      exp_v = {vals[k] == 1023, 10'((vals[k] + 1) % 1024)};
      vectors++;
      if ({inc_o, inc_s} !== exp_v) begin
        miscompares++;
        $display("FAIL incrementer a=%0d: got o=%0b s=%0d expected o=%0b s=%0d",
                 vals[k], inc_o, inc_s, exp_v[10], exp_v[9:0]);
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 0, 1'b1);
    rst_n = 1'b0;
    #3;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs_of(i) !== exp_of(i)) begin
        miscompares++;
        $display("FAIL reset inst%0d: got %b expected %b", i, obs_of(i), exp_of(i));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_of(i) !== exp_of(i)) begin
          miscompares++;
          $display("FAIL start c%0d inst%0d: got %b expected %b", c, i, obs_of(i), exp_of(i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic rdy_seq[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    drive(1'b1, 36, 1'b1);
    tick();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 0, rdy_seq[c]);
      tick();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_of(i) !== exp_of(i)) begin
          miscompares++;
          $display("FAIL backpressure c%0d inst%0d: got %b expected %b", c, i, obs_of(i), exp_of(i));
        end
      end
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1022, 1'b0);
    tick();
    for (int c = 0; c < 7; c++) begin
      if (c == 5) drive(1'b1, 5, 1'b1);
      else drive(1'b0, 0, 1'b1);
      tick();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_of(i) !== exp_of(i)) begin
          miscompares++;
          $display("FAIL wrap c%0d inst%0d: got %b expected %b", c, i, obs_of(i), exp_of(i));
        end
      end
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 100, 1'b0);
    tick();
    drive(1'b1, 512, 1'b1);
    tick();
    drive(1'b0, 0, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs_of(i) !== exp_of(i)) begin
        miscompares++;
        $display("FAIL collision inst%0d: got %b expected %b", i, obs_of(i), exp_of(i));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) == 0,
            ($urandom_range(0, 2) == 0) ? 1018 + int'($urandom_range(0, 5)) : int'($urandom_range(0, 1023)),
            $urandom_range(0, 3) != 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_of(i) !== exp_of(i)) begin
          miscompares++;
          $display("FAIL random c%0d inst%0d: got %b expected %b", c, i, obs_of(i), exp_of(i));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 700, 1'b0);
    tick();
    drive(1'b0, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs_of(i) !== exp_of(i)) begin
        miscompares++;
        $display("FAIL async_reset inst%0d: got %b expected %b", i, obs_of(i), exp_of(i));
      end
    end
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_of(i) !== exp_of(i)) begin
          miscompares++;
          $display("FAIL post_reset c%0d inst%0d: got %b expected %b", c, i, obs_of(i), exp_of(i));
        end
      end
    end
  endtask

  initial begin
    m_hw[0] = 1;
    m_hw[1] = 0;
    model_reset();
    test_incrementer();
    test_reset();
    test_backpressure();
    test_wrap();
    test_collision();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
